seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits: latches a packed hexadecimal value, decodes one digit at a time to active-low segments, and scans the digit enables at a programmable refresh rate. It is the multi-digit, clocked successor to the single-digit hex decoder and sits between the datapath's result registers and the board display pins. Its additional features are tear-free frame-synchronous loading, leading-zero suppression, per-digit decimal points and an anti-ghosting guard cycle.

## Interface
- NUM_DIGITS, 4, number of digits scanned (legal 1..8); digit 0 is least significant
- REFRESH_DIV, 50000, clock cycles per digit slot (legal >= 2)
- DIGIT_ACTIVE_LOW, 1, 1: `an` bit low enables the digit; 0: high enables it
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous, active-high
- value  input  4*NUM_DIGITS  packed nibbles; bits [4i+3:4i] are digit i
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
- load  input  1  single-cycle strobe that captures `value` and `dp_in`
- en  input  1  display enable; 0 blanks all outputs and scanning continues
- blank_lz  input  1  1 = suppress leading zeros
- seg  output  7  {A,B,C,D,E,F,G}, active-low
- dp_n  output  1  decimal point, active-low
- an  output  NUM_DIGITS  digit enables, polarity per DIGIT_ACTIVE_LOW
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Prescaler `div_cnt` counts 0..REFRESH_DIV-1 and wraps. On its terminal count, `idx` advances, going from NUM_DIGITS-1 back to 0.
- Two storage stages:
  - Pending: `load` writes `value` and `dp_in` into the pending registers and sets `pend_v`. A later load overwrites the pending contents, so the last load wins.
  - Shadow: on the wrap edge (terminal count with idx = NUM_DIGITS-1), pending moves to shadow if `pend_v` is set, and `pend_v` clears. If `load` is asserted on the wrap edge itself, `value` and `dp_in` go directly to shadow and `pend_v` clears.
  - The display always shows shadow, so it never changes mid-frame.
- Decode (A..G):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Leading-zero suppression: with blank_lz = 1, digit i>0 is blanked when its nibble and every more-significant nibble are 0. Digit 0 is never blanked. A blanked digit drives seg = 1111111 while `an` still enables it, and the dp still follows `dp_in`.
- Output selection for the next cycle:
  - en = 0, or div_cnt = REFRESH_DIV-1 (guard slot): seg = 1111111, dp_n = 1, all digits disabled.
  - Otherwise: only digit `idx` is enabled, seg = decode(shadow nibble idx) or blank, dp_n = ~shadow_dp[idx].
- frame_done is registered and is 1 for exactly the cycle after each wrap edge, independent of `en`.
- Reset values (asynchronous): div_cnt = 0, idx = 0, shadow = 0, shadow_dp = 0, pend_v = 0, seg = 1111111, dp_n = 1, an = all disabled, frame_done = 0.

## Timing
- seg, dp_n, an and frame_done are registered: each output at edge t reflects div_cnt, idx and shadow as they were before edge t.
- Each digit is lit for REFRESH_DIV-1 consecutive cycles, followed by one all-off guard cycle.
- One frame is NUM_DIGITS*REFRESH_DIV cycles. frame_done has that period.
- Latency from load to display:
  - The load updates the display from the first slot of the next frame.
  - A load at the wrap edge updates the display immediately, at digit 0 of the new frame.
- Reset asserted mid-scan forces every output to its reset value immediately, without waiting for a clock edge. After release, the first edge lights digit 0 and the first wrap occurs NUM_DIGITS*REFRESH_DIV edges later.
- Toggling `en` takes effect on the next edge and never disturbs div_cnt or idx.
- When NUM_DIGITS = 1, idx is constant 0 and every terminal count is a wrap.

## Test plan
All scenarios use NUM_DIGITS = 4, REFRESH_DIV = 4, DIGIT_ACTIVE_LOW = 1.
- Reset: assert rst asynchronously in the middle of digit 2 -> seg = 7F, dp_n = 1, an = F and frame_done = 0 before the next edge. After release, digit 0 is lit on the first edge.
- Scan: load 16'h12AF, then observe one frame ->
  - digit 0 shows F = 0111000 with an = E, digit 1 shows A = 0001000 with an = D, digit 2 shows 2 = 0010010 with an = B, digit 3 shows 1 = 1001111 with an = 7;
  - each digit is lit 3 cycles followed by a 1-cycle all-off guard;
  - frame_done pulses every 16 cycles.
- Leading-zero suppression: blank_lz = 1 ->
  - value 16'h0040: digits 3 and 2 show seg = 7F with their `an` active, digit 1 shows 1001100, digit 0 shows 0000001;
  - value 16'h0000: only digit 0 shows 0.
- Load timing: load 16'h1111 and then 16'h2222 within one frame -> the display stays old until the wrap, then shows 2222. A load of 16'h3333 on the wrap edge shows 3 on digit 0 of the immediately following frame.
- Enable: en = 0 for 2 frames -> an = F, seg = 7F, dp_n = 1, and frame_done keeps its 16-cycle period. Restoring en = 1 resumes at the current idx with no phase slip.
- Decimal point: dp_in = 4'b0100 loaded -> dp_n = 0 only during digit 2's three lit cycles, and it stays 0 even when digit 2 is blanked by blank_lz.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: frame-synchronous value loading,
// leading-zero blanking, per-digit decimal points and a guard slot between digits.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    en,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

   logic [DIV_W-1:0]        div_cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] pend_val, shadow;
   logic [NUM_DIGITS-1:0]   pend_dp, shadow_dp;
   logic                    pend_v;

   logic                    tc, wrap;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blank, zero_above;
   logic [NUM_DIGITS-1:0]   an_on;
   logic [6:0]              seg_d;
   logic                    dp_n_d;
   logic [NUM_DIGITS-1:0]   an_d;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign tc   = (div_cnt == DIV_LAST);
   assign wrap = tc && (idx == IDX_LAST);

   // Walk from the most significant digit down so zero_above covers digit i and all above it.
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (shadow[4*i +: 4] == 4'h0);
         if (idx == IDX_W'(i)) begin
            cur_nib   = shadow[4*i +: 4];
            cur_dp    = shadow_dp[i];
            cur_blank = blank_lz && (i > 0) && zero_above;
         end
      end
   end

   always_comb begin
      seg_d  = 7'h7F;
      dp_n_d = 1'b1;
      an_d   = AN_OFF;
      an_on  = NUM_DIGITS'(1) << idx;
      if (en && !tc) begin
         seg_d  = cur_blank ? 7'h7F : decode(cur_nib);
         dp_n_d = ~cur_dp;
         an_d   = DIGIT_ACTIVE_LOW ? ~an_on : an_on;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_v     <= 1'b0;
         shadow     <= '0;
         shadow_dp  <= '0;
         seg        <= 7'h7F;
         dp_n       <= 1'b1;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         div_cnt <= tc ? '0 : div_cnt + 1'b1;
         if (tc)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

         // A load coinciding with the wrap bypasses pending so it shows in the new frame.
         if (load && wrap) begin
            shadow    <= value;
            shadow_dp <= dp_in;
            pend_v    <= 1'b0;
         end else begin
            if (wrap) begin
               if (pend_v) begin
                  shadow    <= pend_val;
                  shadow_dp <= pend_dp;
               end
               pend_v <= 1'b0;
            end
            if (load) begin
               pend_val <= value;
               pend_dp  <= dp_in;
               pend_v   <= 1'b1;
            end
         end

         seg        <= seg_d;
         dp_n       <= dp_n_d;
         an         <= an_d;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 4-cycle slots, active-low anodes):
// frame-level reference model checked every cycle, plus literal spot checks.
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0, en = 1'b1, blank_lz = 1'b0;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   seven_seg_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
      .en(en), .blank_lz(blank_lz), .seg(seg), .dp_n(dp_n), .an(an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Model state: position within the 16-cycle frame plus the two storage stages.
   int          m_phase;
   logic [15:0] m_shadow, m_pend;
   logic [3:0]  m_sdp, m_pdp;
   bit          m_pv;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_shadow = '0;
      m_pend   = '0;
      m_sdp    = '0;
      m_pdp    = '0;
      m_pv     = 0;
   endtask

   task automatic cycle();
      logic [6:0] e_seg;
      logic       e_dp, e_fd;
      logic [3:0] e_an, nib;
      int         slot, dig;
      slot  = m_phase % 4;
      dig   = m_phase / 4;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = 4'hF;
      if (en && slot != 3) begin
         nib  = 4'(m_shadow >> (4 * dig));
         e_an = 4'hF & ~(4'(1) << dig);
         if (blank_lz && dig > 0 && (m_shadow >> (4 * dig)) == 16'h0)
            e_seg = 7'h7F;
         else
            e_seg = seg_tab[nib];
         e_dp = ~m_sdp[dig];
      end
      e_fd = (m_phase == 15);
      @(posedge clk);
      #1;
      chk("seg", seg, e_seg);
      chk("dp_n", dp_n, e_dp);
      chk("an", an, e_an);
      chk("frame_done", frame_done, e_fd);
      if (load && m_phase == 15) begin
         m_shadow = value;
         m_sdp    = dp_in;
         m_pv     = 0;
      end else begin
         if (m_phase == 15 && m_pv) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
         end
         if (m_phase == 15) m_pv = 0;
         if (load) begin
            m_pend = value;
            m_pdp  = dp_in;
            m_pv   = 1;
         end
      end
      m_phase = (m_phase + 1) % 16;
   endtask

   task automatic run_to_phase(input int p);
      for (int k = 0; k < 16 && m_phase != p; k++) cycle();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      cycle();
      load  = 1'b0;
   endtask

   initial begin
      int fd_first, fd_gap, cnt, bad;
      logic [15:0] mask;

      // Reset state
      #12;
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp_n", dp_n, 1'b1);
      chk("rst_an", an, 4'hF);
      chk("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      model_reset();

      // Scan of 12AF
      cycle();
      chk("first_edge_an", an, 4'hE);
      do_load(16'h12AF, 4'h0);
      run_to_phase(0);
      cycle(); chk("scan_d0_seg", seg, 7'b0111000); chk("scan_d0_an", an, 4'hE);
      run_to_phase(4);
      cycle(); chk("scan_d1_seg", seg, 7'b0001000); chk("scan_d1_an", an, 4'hD);
      run_to_phase(8);
      cycle(); chk("scan_d2_seg", seg, 7'b0010010); chk("scan_d2_an", an, 4'hB);
      run_to_phase(12);
      cycle(); chk("scan_d3_seg", seg, 7'b1001111); chk("scan_d3_an", an, 4'h7);
      run_to_phase(15);
      cycle(); chk("guard_an", an, 4'hF); chk("guard_seg", seg, 7'h7F);
      fd_first = -1; fd_gap = -1; cnt = 0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (k < 32 && an == 4'hE) cnt++;
         if (frame_done) begin
            if (fd_first < 0) fd_first = k;
            else if (fd_gap < 0) fd_gap = k - fd_first;
         end
      end
      chk("frame_period", fd_gap, 16);
      chk("d0_lit_cycles", cnt, 6);

      // Leading-zero suppression
      blank_lz = 1'b1;
      do_load(16'h0040, 4'h0);
      run_to_phase(0);
      cycle(); chk("lz_d0_seg", seg, 7'b0000001);
      run_to_phase(4);
      cycle(); chk("lz_d1_seg", seg, 7'b1001100);
      run_to_phase(8);
      cycle(); chk("lz_d2_seg", seg, 7'h7F); chk("lz_d2_an", an, 4'hB);
      run_to_phase(12);
      cycle(); chk("lz_d3_seg", seg, 7'h7F); chk("lz_d3_an", an, 4'h7);
      do_load(16'h0000, 4'h0);
      run_to_phase(0);
      cycle(); chk("lz0_d0_seg", seg, 7'b0000001);
      run_to_phase(4);
      cycle(); chk("lz0_d1_seg", seg, 7'h7F);

      // Load timing
      blank_lz = 1'b0;
      run_to_phase(2);
      do_load(16'h1111, 4'h0);
      run_to_phase(6);
      do_load(16'h2222, 4'h0);
      run_to_phase(12);
      cycle(); chk("ld_old_seg", seg, 7'b0000001);
      run_to_phase(0);
      cycle(); chk("ld_new_seg", seg, 7'b0010010);
      run_to_phase(15);
      do_load(16'h3333, 4'h0);
      cycle(); chk("ld_wrap_seg", seg, 7'b0000110); chk("ld_wrap_an", an, 4'hE);

      // Enable off for two frames
      en = 1'b0; bad = 0; cnt = 0;
      for (int k = 0; k < 32; k++) begin
         cycle();
         if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) bad++;
         if (frame_done) cnt++;
      end
      chk("en0_blank", bad, 0);
      chk("en0_fd_count", cnt, 2);
      run_to_phase(5);
      en = 1'b1;
      cycle(); chk("en1_resume_an", an, 4'hD); chk("en1_resume_seg", seg, 7'b0000110);

      // Decimal point on a blanked digit
      blank_lz = 1'b1;
      do_load(16'h0000, 4'b0100);
      run_to_phase(0);
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (dp_n == 1'b0) begin
            cnt++;
            if (an !== 4'hB || seg !== 7'h7F) bad++;
         end
      end
      chk("dp_low_cycles", cnt, 3);
      chk("dp_digit2_blank", bad, 0);

      // Randomized traffic
      for (int k = 0; k < 500; k++) begin
         case ($urandom_range(0, 3))
            0: mask = 16'h000F;
            1: mask = 16'h00FF;
            2: mask = 16'h0FFF;
            default: mask = 16'hFFFF;
         endcase
         value    = 16'($urandom) & mask;
         dp_in    = 4'($urandom);
         load     = ($urandom_range(0, 7) == 0);
         en       = ($urandom_range(0, 9) != 0);
         blank_lz = 1'($urandom);
         cycle();
      end
      load = 1'b0;

      // Asynchronous reset in the middle of digit 2
      en = 1'b1; blank_lz = 1'b0;
      run_to_phase(10);
      #3 rst = 1'b1;
      #1;
      chk("arst_seg", seg, 7'h7F);
      chk("arst_dp_n", dp_n, 1'b1);
      chk("arst_an", an, 4'hF);
      chk("arst_frame_done", frame_done, 1'b0);
      #2 rst = 1'b0;
      model_reset();
      cycle(); chk("arst_first_an", an, 4'hE); chk("arst_first_seg", seg, 7'b0000001);
      for (int k = 0; k < 100; k++) begin
         value = 16'($urandom);
         dp_in = 4'($urandom);
         load  = ($urandom_range(0, 5) == 0);
         en    = ($urandom_range(0, 7) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
